// File: rtl/sr_cmd_driver.sv
// sr_cmd_driver: command-side driver for an sr_flipflop in the same clock domain.
// A single-beat SET/RESET/TOGGLE/NOP request becomes a PULSE_W-cycle S or R pulse.
// The driver then watches q_fb for up to TIMEOUT cycles and reports done or err.
// Commands whose target already equals q_fb complete on the skip path with no pulse.
// S and R are never high together.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   req_valid  command valid
//   req_op     00 NOP, 01 SET, 10 RESET, 11 TOGGLE
//   req_ready  high while idle (a command can be accepted)
//   q_fb       q from the driven flip-flop (same clock domain)
//   S, R       set / reset drive to the flip-flop
//   busy       high while pulsing or waiting for confirmation
//   done       one-cycle pulse, command confirmed (q_fb == target)
//   err        one-cycle pulse, confirmation window expired
module sr_cmd_driver #(
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  output logic       req_ready,
  input  logic       q_fb,
  output logic       S,
  output logic       R,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CntMax = (PULSE_W > TIMEOUT) ? PULSE_W : TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [CntW-1:0] CntSat    = {CntW{1'b1}};
  localparam logic [CntW-1:0] PulseLast = CntW'(PULSE_W);
  localparam logic [CntW-1:0] WaitLast  = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StPulse, StWait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            target_q, target_d;
  logic            s_q, s_d;
  logic            r_q, r_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            busy_q, ready_q;

  logic accept;
  logic req_target;
  logic wait_match;
  logic wait_last;

  assign accept     = req_valid & (state_q == StIdle);
  assign wait_match = (q_fb == target_q);
  assign wait_last  = (cnt_q >= WaitLast);

  // Target level the flip-flop must reach; q_fb is sampled on the accept edge.
  always_comb begin
    req_target = q_fb;
    case (req_op)
      2'b01:   req_target = 1'b1;
      2'b10:   req_target = 1'b0;
      2'b11:   req_target = ~q_fb;
      default: req_target = q_fb;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      target_q <= 1'b0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      s_q      <= s_d;
      r_q      <= r_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= (state_d != StIdle);
      ready_q  <= (state_d == StIdle);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          target_d = req_target;
          // Already at target: skip path, stay idle.
          if (req_target != q_fb) begin
            state_d = StPulse;
            cnt_d   = CntOne;
          end
        end
      end
      StPulse: begin
        // cnt_q counts pulse cycles already driven, including the accept edge.
        if (cnt_q >= PulseLast) begin
          state_d = StWait;
          cnt_d   = '0;
        end else if (cnt_q != CntSat) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StWait: begin
        if (wait_match || wait_last) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q != CntSat) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next values; S/R follow the state being entered so they are never both high.
  always_comb begin
    s_d    = (state_d == StPulse) &  target_d;
    r_d    = (state_d == StPulse) & ~target_d;
    done_d = 1'b0;
    err_d  = 1'b0;
    if (state_q == StIdle && accept && (req_target == q_fb)) begin
      done_d = 1'b1;
    end
    if (state_q == StWait) begin
      done_d = wait_match;
      err_d  = ~wait_match & wait_last;
    end
  end

  assign S         = s_q;
  assign R         = r_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign req_ready = ready_q;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Directed bench for sr_cmd_driver (PULSE_W=2, TIMEOUT=4) with a behavioural flip-flop on S/R.
module tb_sr_cmd_driver;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_op;
  logic       req_ready;
  logic       q_fb;
  logic       S;
  logic       R;
  logic       busy;
  logic       done;
  logic       err;

  logic q_m;
  logic force_en;

  int vectors;
  int miscompares;

  sr_cmd_driver #(
    .PULSE_W(2),
    .TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_op   (req_op),
    .req_ready(req_ready),
    .q_fb     (q_fb),
    .S        (S),
    .R        (R),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flip-flop model: q <= S ? 1 : R ? 0 : q.
  always @(posedge clk or negedge reset) begin
    if (!reset)  q_m <= 1'b0;
    else if (S)  q_m <= 1'b1;
    else if (R)  q_m <= 1'b0;
  end

  assign q_fb = force_en ? 1'b0 : q_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int outs;
    int accepts;
    int dones;
    int errs;
    int v_sr;
    int v_rdy;
    int v_both;
    int v_dsr;
    int cyc;

    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_op      = 2'b00;
    force_en    = 1'b0;

    // Reset values.
    #1 reset = 1'b0;
    #1;
    check("rst_S", S, 0);
    check("rst_R", R, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // 1: reset mid-operation while S is high.
    req_valid = 1'b1;
    req_op    = 2'b01;
    tick();
    req_valid = 1'b0;
    check("t1_S_before", S, 1);
    #3 reset = 1'b0;
    #1;
    check("t1_S", S, 0);
    check("t1_R", R, 0);
    check("t1_busy", busy, 0);
    check("t1_ready", req_ready, 1);
    tick();
    reset = 1'b1;
    outs = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || err) outs++;
    end
    check("t1_no_outcome", outs, 0);

    // 2: q=0, SET -> S for 2 cycles, done after edge 3.
    check("t2_q0", q_fb, 0);
    req_valid = 1'b1;
    req_op    = 2'b01;
    tick();                                   // edge 0
    req_valid = 1'b0;
    check("t2_S_e0", S, 1);
    check("t2_R_e0", R, 0);
    check("t2_busy_e0", busy, 1);
    check("t2_ready_e0", req_ready, 0);
    tick();                                   // edge 1
    check("t2_S_e1", S, 1);
    check("t2_q_e1", q_fb, 1);
    check("t2_done_e1", done, 0);
    tick();                                   // edge 2
    check("t2_S_e2", S, 0);
    check("t2_busy_e2", busy, 1);
    check("t2_done_e2", done, 0);
    tick();                                   // edge 3
    check("t2_done_e3", done, 1);
    check("t2_err_e3", err, 0);
    check("t2_ready_e3", req_ready, 1);
    tick();
    check("t2_done_e4", done, 0);

    // 3: q=1, TOGGLE -> R for 2 cycles, done after edge 3; then NOP skip.
    req_valid = 1'b1;
    req_op    = 2'b11;
    tick();
    req_valid = 1'b0;
    check("t3_R_e0", R, 1);
    check("t3_S_e0", S, 0);
    tick();
    check("t3_R_e1", R, 1);
    check("t3_q_e1", q_fb, 0);
    tick();
    check("t3_R_e2", R, 0);
    check("t3_done_e2", done, 0);
    tick();
    check("t3_done_e3", done, 1);
    check("t3_err_e3", err, 0);
    req_valid = 1'b1;
    req_op    = 2'b00;
    tick();
    req_valid = 1'b0;
    check("t3_nop_done", done, 1);
    check("t3_nop_S", S, 0);
    check("t3_nop_R", R, 0);
    check("t3_nop_ready", req_ready, 1);
    tick();
    check("t3_nop_done_off", done, 0);

    // 4: bring q to 1, then SET takes the skip path twice back-to-back.
    req_valid = 1'b1;
    req_op    = 2'b01;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    check("t4_setup_done", done, 1);
    check("t4_setup_q", q_fb, 1);
    req_valid = 1'b1;
    req_op    = 2'b01;
    tick();
    check("t4_skip1_done", done, 1);
    check("t4_skip1_S", S, 0);
    check("t4_skip1_ready", req_ready, 1);
    check("t4_skip1_busy", busy, 0);
    tick();
    req_valid = 1'b0;
    check("t4_skip2_done", done, 1);
    check("t4_skip2_S", S, 0);
    tick();
    check("t4_done_off", done, 0);

    // 5: q_fb stuck at 0, SET -> err after edge 6, no done.
    force_en  = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'b01;
    tick();                                   // edge 0
    req_valid = 1'b0;
    check("t5_S_e0", S, 1);
    tick();                                   // edge 1
    check("t5_S_e1", S, 1);
    tick();                                   // edge 2
    check("t5_S_e2", S, 0);
    outs = 0;
    for (int i = 3; i <= 5; i++) begin
      tick();
      if (done || err) outs++;
    end
    check("t5_quiet_e3_e5", outs, 0);
    check("t5_busy_e5", busy, 1);
    tick();                                   // edge 6
    check("t5_err_e6", err, 1);
    check("t5_done_e6", done, 0);
    check("t5_ready_e6", req_ready, 1);
    tick();
    check("t5_err_off", err, 0);
    force_en = 1'b0;

    // 6: random command stream.
    accepts = 0; dones = 0; errs = 0;
    v_sr = 0; v_rdy = 0; v_both = 0; v_dsr = 0; cyc = 0;
    while (accepts < 1000 && cyc < 20000) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_op    = 2'($urandom_range(0, 3));
      if (req_valid && req_ready) accepts++;
      tick();
      cyc++;
      if (done) dones++;
      if (err) errs++;
      if (S && R) v_sr++;
      if (busy == req_ready) v_rdy++;
      if (done && err) v_both++;
      if ((done || err) && (S || R)) v_dsr++;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) dones++;
      if (err) errs++;
      if (S && R) v_sr++;
      if (busy == req_ready) v_rdy++;
    end
    check("t6_accepts", accepts, 1000);
    check("t6_outcomes", dones + errs, accepts);
    check("t6_no_err", errs, 0);
    check("t6_s_and_r", v_sr, 0);
    check("t6_busy_ready", v_rdy, 0);
    check("t6_done_and_err", v_both, 0);
    check("t6_outcome_during_pulse", v_dsr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
